// File: rtl/video_rx_timing_detect_if.sv
// ---------------------------------------------------------------------------
// video_rx_timing_detect_if
// Parallel RGB video bus as produced by the HDMI driver / test pattern path.
//   RGB_Data   24  pixel {R,G,B}
//   RGB_HSync   1  horizontal sync (polarity chosen by the receiver)
//   RGB_VSync   1  vertical sync (polarity chosen by the receiver)
//   RGB_VDE     1  active video enable
// Modports: master drives the bus (source), slave receives it.
// ---------------------------------------------------------------------------
interface video_rx_timing_detect_if;
  logic [23:0] RGB_Data;
  logic        RGB_HSync;
  logic        RGB_VSync;
  logic        RGB_VDE;

  modport master (
    output RGB_Data,
    output RGB_HSync,
    output RGB_VSync,
    output RGB_VDE
  );

  modport slave (
    input RGB_Data,
    input RGB_HSync,
    input RGB_VSync,
    input RGB_VDE
  );
endinterface

// File: rtl/video_rx_timing_detect.sv
// ---------------------------------------------------------------------------
// video_rx_timing_detect
// Receive side of the RGB video interface. Recovers per-pixel X/Y coordinates,
// measures active/total line and frame geometry and declares lock once the
// geometry has repeated for LOCK_FRAMES consecutive frames.
// Ports:
//   clk          pixel clock
//   Rst          asynchronous reset, active-high (released synchronously)
//   vid          video input bus (slave modport)
//   Pix_Data     pixel data, aligned with Pix_Valid (0 when not valid)
//   Pix_Valid    active pixel, only after a VSync leading edge has been seen
//   Pix_X/Pix_Y  column / row of Pix_Data, saturating at 4095
//   Frame_Start  pulse with the first valid pixel of a frame
//   H_Active, V_Active, H_Total, V_Total  geometry of last completed frame
//   Locked       geometry stable
//   Timing_Err   one-cycle pulse on loss of lock (mismatch or timeout)
// All Pix_* outputs trail the input pins by exactly two clocks.
// ---------------------------------------------------------------------------
module video_rx_timing_detect #(
  parameter int SYNC_POL    = 1,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 4000000
) (
  input  logic                    clk,
  input  logic                    Rst,
  video_rx_timing_detect_if.slave vid,
  output logic [23:0]             Pix_Data,
  output logic                    Pix_Valid,
  output logic [11:0]             Pix_X,
  output logic [11:0]             Pix_Y,
  output logic                    Frame_Start,
  output logic [11:0]             H_Active,
  output logic [11:0]             V_Active,
  output logic [11:0]             H_Total,
  output logic [11:0]             V_Total,
  output logic                    Locked,
  output logic                    Timing_Err
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);
  localparam logic [22:0] WD_LAST = 23'(TIMEOUT - 1);
  localparam logic [22:0] WD_HOLD = 23'(TIMEOUT);

  // Reset synchroniser: assertion is immediate, release waits for two clocks.
  logic [1:0] rst_sync;
  logic       rst_i;

  // Shift a released reset out through two flops.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst_i = rst_sync[1];

  // Input stage (s1) and one-cycle history (s2); syncs are normalised to
  // active-high here so all edge logic below is polarity independent.
  logic [23:0] data1;
  logic        hs1, vs1, vde1;
  logic        hs2, vs2, vde2;

  // Register the pins once, then keep the previous sample for edge detection.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      data1 <= 24'd0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      vde1  <= 1'b0;
      hs2   <= 1'b0;
      vs2   <= 1'b0;
      vde2  <= 1'b0;
    end else begin
      data1 <= vid.RGB_Data;
      hs1   <= (SYNC_POL != 0) ? vid.RGB_HSync : ~vid.RGB_HSync;
      vs1   <= (SYNC_POL != 0) ? vid.RGB_VSync : ~vid.RGB_VSync;
      vde1  <= vid.RGB_VDE;
      hs2   <= hs1;
      vs2   <= vs1;
      vde2  <= vde1;
    end
  end

  logic hs_lead, vs_lead, vde_rise, vde_fall;

  assign hs_lead  = hs1 & ~hs2;
  assign vs_lead  = vs1 & ~vs2;
  assign vde_rise = vde1 & ~vde2;
  assign vde_fall = ~vde1 & vde2;

  // Frame bookkeeping state, owned by the FSM block further down.
  state_t      state;
  logic [3:0]  match_cnt;
  logic        frame_seen;
  logic [22:0] wd_cnt;

  // Pixel coordinate next-state logic.
  logic        valid_s;
  logic [11:0] x_s;
  logic [11:0] y_s;
  logic        y_first_s;
  logic        y_first;

  // Next pixel coordinates; y_first marks that the next VDE rise is row 0.
  always_comb begin
    valid_s   = vde1 & (frame_seen | vs_lead);
    y_first_s = y_first | vs_lead;
    x_s       = Pix_X;
    y_s       = Pix_Y;
    if (vde1) begin
      if (vde_rise) begin
        x_s = 12'd0;
      end else if (Pix_X != CNT_MAX) begin
        x_s = Pix_X + 12'd1;
      end else begin
        x_s = Pix_X;
      end
    end else begin
      x_s = Pix_X;
    end
    if (vde_rise) begin
      if (y_first_s) begin
        y_s = 12'd0;
      end else if (Pix_Y != CNT_MAX) begin
        y_s = Pix_Y + 12'd1;
      end else begin
        y_s = Pix_Y;
      end
    end else begin
      y_s = Pix_Y;
    end
  end

  // Pixel output registers (second pipeline stage).
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      Pix_Data    <= 24'd0;
      Pix_Valid   <= 1'b0;
      Pix_X       <= 12'd0;
      Pix_Y       <= 12'd0;
      Frame_Start <= 1'b0;
      y_first     <= 1'b0;
    end else begin
      Pix_Data    <= valid_s ? data1 : 24'd0;
      Pix_Valid   <= valid_s;
      Pix_X       <= x_s;
      Pix_Y       <= y_s;
      Frame_Start <= valid_s & (x_s == 12'd0) & (y_s == 12'd0);
      y_first     <= vde_rise ? 1'b0 : y_first_s;
    end
  end

  // Running geometry counters of the frame in progress.
  logic [11:0] h_clk;
  logic [11:0] line_total;
  logic [11:0] act_cnt;
  logic [11:0] line_active;
  logic [11:0] v_line;
  logic [11:0] act_lines;

  // Line and frame counters; each saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      h_clk       <= 12'd0;
      line_total  <= 12'd0;
      act_cnt     <= 12'd0;
      line_active <= 12'd0;
      v_line      <= 12'd0;
      act_lines   <= 12'd0;
    end else begin
      if (hs_lead) begin
        h_clk      <= 12'd1;
        line_total <= h_clk;
      end else if (h_clk != CNT_MAX) begin
        h_clk <= h_clk + 12'd1;
      end else begin
        h_clk <= h_clk;
      end

      if (vde_rise) begin
        act_cnt <= 12'd1;
      end else if (vde1 && (act_cnt != CNT_MAX)) begin
        act_cnt <= act_cnt + 12'd1;
      end else begin
        act_cnt <= act_cnt;
      end
      if (vde_fall) begin
        line_active <= act_cnt;
      end else begin
        line_active <= line_active;
      end

      // A VSync edge that coincides with an HSync edge already counts as line 1.
      if (vs_lead) begin
        v_line <= hs_lead ? 12'd1 : 12'd0;
      end else if (hs_lead && (v_line != CNT_MAX)) begin
        v_line <= v_line + 12'd1;
      end else begin
        v_line <= v_line;
      end

      if (vs_lead) begin
        act_lines <= vde_rise ? 12'd1 : 12'd0;
      end else if (vde_rise && (act_lines != CNT_MAX)) begin
        act_lines <= act_lines + 12'd1;
      end else begin
        act_lines <= act_lines;
      end
    end
  end

  // Measurement of the frame that closes on this VSync edge. Line values that
  // are being latched in this very cycle are taken straight from the counters.
  logic [11:0] h_act_s;
  logic [11:0] h_tot_s;
  logic [11:0] v_act_s;
  logic [11:0] v_tot_s;
  logic        match_s;

  // Assemble the closing-frame measurement and compare with the previous one.
  always_comb begin
    h_act_s = vde_fall ? act_cnt : line_active;
    h_tot_s = hs_lead ? h_clk : line_total;
    v_act_s = act_lines;
    v_tot_s = v_line;
    match_s = (h_act_s == H_Active) && (v_act_s == V_Active) &&
              (h_tot_s == H_Total) && (v_tot_s == V_Total);
  end

  // Lock FSM, watchdog and geometry outputs; the FSM only moves on a VSync
  // edge, except that the watchdog can force it back to UNLOCKED.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state      <= UNLOCKED;
      match_cnt  <= 4'd0;
      frame_seen <= 1'b0;
      wd_cnt     <= 23'd0;
      H_Active   <= 12'd0;
      V_Active   <= 12'd0;
      H_Total    <= 12'd0;
      V_Total    <= 12'd0;
      Locked     <= 1'b0;
      Timing_Err <= 1'b0;
    end else begin
      Timing_Err <= 1'b0;
      if (vs_lead) begin
        wd_cnt     <= 23'd0;
        frame_seen <= 1'b1;
        if (frame_seen) begin
          H_Active <= h_act_s;
          V_Active <= v_act_s;
          H_Total  <= h_tot_s;
          V_Total  <= v_tot_s;
          case (state)
            UNLOCKED: begin
              state     <= CHECK;
              match_cnt <= 4'd0;
              Locked    <= 1'b0;
            end
            CHECK: begin
              if (match_s) begin
                match_cnt <= match_cnt + 4'd1;
                if ((match_cnt + 4'd1) >= LOCK_N) begin
                  state  <= LOCKED;
                  Locked <= 1'b1;
                end else begin
                  state  <= CHECK;
                  Locked <= 1'b0;
                end
              end else begin
                match_cnt <= 4'd0;
                state     <= CHECK;
                Locked    <= 1'b0;
              end
            end
            LOCKED: begin
              if (!match_s) begin
                state      <= UNLOCKED;
                match_cnt  <= 4'd0;
                Locked     <= 1'b0;
                Timing_Err <= 1'b1;
              end else begin
                state  <= LOCKED;
                Locked <= 1'b1;
              end
            end
            default: begin
              state     <= UNLOCKED;
              match_cnt <= 4'd0;
              Locked    <= 1'b0;
            end
          endcase
        end
      end else if (wd_cnt == WD_LAST) begin
        // Timeout fires once, then the counter parks until the next VSync edge.
        wd_cnt     <= WD_HOLD;
        state      <= UNLOCKED;
        match_cnt  <= 4'd0;
        frame_seen <= 1'b0;
        Locked     <= 1'b0;
        Timing_Err <= (state == LOCKED);
      end else if (wd_cnt != WD_HOLD) begin
        wd_cnt <= wd_cnt + 23'd1;
      end else begin
        wd_cnt <= wd_cnt;
      end
    end
  end

endmodule

// File: tb/tb_video_rx_timing_detect.sv
// ---------------------------------------------------------------------------
// tb_video_rx_timing_detect
// Directed bench: 24x12 total frames with 16x8 (or 20x8) active area,
// syncs active-high, VSync and HSync leading edges coincide at frame start.
// ---------------------------------------------------------------------------
module tb_video_rx_timing_detect;

  logic        clk;
  logic        Rst;
  logic [23:0] Pix_Data;
  logic        Pix_Valid;
  logic [11:0] Pix_X;
  logic [11:0] Pix_Y;
  logic        Frame_Start;
  logic [11:0] H_Active;
  logic [11:0] V_Active;
  logic [11:0] H_Total;
  logic [11:0] V_Total;
  logic        Locked;
  logic        Timing_Err;

  video_rx_timing_detect_if vif ();

  video_rx_timing_detect #(
    .SYNC_POL(1),
    .LOCK_FRAMES(2),
    .TIMEOUT(1000)
  ) dut (
    .clk(clk),
    .Rst(Rst),
    .vid(vif),
    .Pix_Data(Pix_Data),
    .Pix_Valid(Pix_Valid),
    .Pix_X(Pix_X),
    .Pix_Y(Pix_Y),
    .Frame_Start(Frame_Start),
    .H_Active(H_Active),
    .V_Active(V_Active),
    .H_Total(H_Total),
    .V_Total(V_Total),
    .Locked(Locked),
    .Timing_Err(Timing_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmps  = 0;
  int fails = 0;

  // Per-frame observations filled in by send_frame.
  logic        lk_pre, lk_post;
  int          err_pulses, fs_pulses;
  logic [11:0] last_x, last_y;
  logic [23:0] ramp;
  // Input driven in the previous cycle; outputs sampled now must match it.
  logic        prev_v;
  logic [23:0] prev_d;
  int          prev_x, prev_y;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input logic vde);
    vif.RGB_HSync = 1'b0;
    vif.RGB_VSync = 1'b0;
    vif.RGB_VDE   = vde;
    vif.RGB_Data  = ramp;
    ramp          = ramp + 24'h010203;
    prev_v        = 1'b0;
  endtask

  // Sends nl lines of a 24-clock-per-line frame; pixel checks when chk_pix.
  task automatic send_frame(input int h_act, input int v_act, input bit chk_pix, input int nl);
    logic cur_v;
    lk_pre = 1'b0; lk_post = 1'b0; err_pulses = 0; fs_pulses = 0;
    last_x = 12'd0; last_y = 12'd0;
    for (int l = 0; l < nl; l++) begin
      for (int c = 0; c < 24; c++) begin
        cur_v = (l >= 2) && (l < 2 + v_act) && (c >= 4) && (c < 4 + h_act);
        vif.RGB_HSync = (c < 2);
        vif.RGB_VSync = (l < 2);
        vif.RGB_VDE   = cur_v;
        vif.RGB_Data  = ramp;
        tick();
        if (Timing_Err) err_pulses++;
        if (Frame_Start) fs_pulses++;
        if (Pix_Valid) begin
          last_x = Pix_X;
          last_y = Pix_Y;
        end
        if (l == 0 && c == 0) lk_pre = Locked;
        if (l == 0 && c == 1) lk_post = Locked;
        if (chk_pix) begin
          chk("pix_valid", Pix_Valid, prev_v);
          chk("frame_start", Frame_Start, prev_v && prev_x == 0 && prev_y == 0);
          if (prev_v) begin
            chk("pix_data", Pix_Data, prev_d);
            chk("pix_x", Pix_X, prev_x);
            chk("pix_y", Pix_Y, prev_y);
          end
        end
        prev_v = cur_v;
        prev_d = ramp;
        prev_x = c - 4;
        prev_y = l - 2;
        ramp   = ramp + 24'h010203;
      end
    end
  endtask

  initial begin
    logic [127:0] acc;
    int           vcnt;

    ramp = 24'h000001;
    prev_v = 1'b0; prev_d = 24'd0; prev_x = 0; prev_y = 0;
    Rst = 1'b1;
    vif.RGB_Data = 24'd0; vif.RGB_HSync = 1'b0; vif.RGB_VSync = 1'b0; vif.RGB_VDE = 1'b0;

    // 1: reset with toggling inputs, then release with VDE high and no syncs
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      vif.RGB_HSync = i[0];
      vif.RGB_VSync = i[1];
      vif.RGB_VDE   = i[2];
      vif.RGB_Data  = 24'($urandom);
      tick();
      acc = acc | {Pix_Data, Pix_Valid, Pix_X, Pix_Y, Frame_Start, H_Active,
                   V_Active, H_Total, V_Total, Locked, Timing_Err};
    end
    chk("reset_outputs", acc, 128'd0);
    vif.RGB_HSync = 1'b0; vif.RGB_VSync = 1'b0; vif.RGB_VDE = 1'b1;
    Rst = 1'b0;
    acc = '0;
    for (int i = 0; i < 40; i++) begin
      drive_idle((i % 8) < 5);
      tick();
      acc = acc | {Pix_Valid, Frame_Start, H_Active, V_Active, H_Total, V_Total,
                   Locked, Timing_Err};
    end
    chk("post_release_quiet", acc, 128'd0);

    // 2: four VSync edges of a 16x8 / 24x12 stream -> lock
    send_frame(16, 8, 1'b0, 12);
    chk("f1_locked", lk_post, 1'b0);
    send_frame(16, 8, 1'b0, 12);
    chk("f2_locked", lk_post, 1'b0);
    send_frame(16, 8, 1'b0, 12);
    chk("f3_locked", lk_post, 1'b0);
    send_frame(16, 8, 1'b0, 12);
    chk("f4_locked_before", lk_pre, 1'b0);
    chk("f4_locked_after", lk_post, 1'b1);
    chk("f4_no_err", err_pulses, 0);
    chk("h_active_16", H_Active, 12'd16);
    chk("v_active_8", V_Active, 12'd8);
    chk("h_total_24", H_Total, 12'd24);
    chk("v_total_12", V_Total, 12'd12);

    // 3: locked stream, every pixel checked against a 2-clock delayed copy
    for (int f = 0; f < 2; f++) begin
      send_frame(16, 8, 1'b1, 12);
      chk("lock_held", lk_post, 1'b1);
      chk("frame_start_once", fs_pulses, 1);
      chk("last_x_15", last_x, 12'd15);
      chk("last_y_7", last_y, 12'd7);
    end

    // 4: one 20-wide frame breaks lock at its closing edge, then relock
    send_frame(20, 8, 1'b0, 12);
    chk("w20a_locked", lk_post, 1'b1);
    chk("w20a_no_err", err_pulses, 0);
    send_frame(20, 8, 1'b0, 12);
    chk("w20b_locked_before", lk_pre, 1'b1);
    chk("w20b_unlocked", lk_post, 1'b0);
    chk("w20b_err_pulse", err_pulses, 1);
    chk("h_active_20", H_Active, 12'd20);
    send_frame(20, 8, 1'b0, 12);
    chk("w20c_locked", lk_post, 1'b0);
    send_frame(20, 8, 1'b0, 12);
    chk("w20d_locked", lk_post, 1'b0);
    send_frame(20, 8, 1'b0, 12);
    chk("w20e_relocked", lk_post, 1'b1);
    chk("w20e_no_err", err_pulses, 0);

    // 5: syncs idle -> watchdog unlock, VDE ignored until next VSync edge
    err_pulses = 0;
    for (int i = 0; i < 600; i++) begin
      drive_idle(1'b0);
      tick();
      if (Timing_Err) err_pulses++;
    end
    chk("wd_before_locked", Locked, 1'b1);
    chk("wd_before_err", err_pulses, 0);
    for (int i = 0; i < 500; i++) begin
      drive_idle(1'b0);
      tick();
      if (Timing_Err) err_pulses++;
    end
    chk("wd_after_locked", Locked, 1'b0);
    chk("wd_err_pulse", err_pulses, 1);
    vcnt = 0;
    for (int i = 0; i < 60; i++) begin
      drive_idle((i % 8) < 4);
      tick();
      if (Pix_Valid) vcnt++;
    end
    chk("wd_vde_ignored", vcnt, 0);
    send_frame(16, 8, 1'b0, 12);
    chk("g1_locked", lk_post, 1'b0);
    chk("g1_frame_start", fs_pulses, 1);

    // 6: relock, then reset mid-frame; relock needs four VSync edges again
    send_frame(16, 8, 1'b0, 12);
    send_frame(16, 8, 1'b0, 12);
    send_frame(16, 8, 1'b0, 12);
    chk("g4_locked", lk_post, 1'b1);
    send_frame(16, 8, 1'b0, 5);
    chk("g5_locked_mid", Locked, 1'b1);
    Rst = 1'b1;
    #1;
    chk("rst_async_clear", {Pix_Data, Pix_Valid, Pix_X, Pix_Y, Frame_Start, H_Active,
                            V_Active, H_Total, V_Total, Locked, Timing_Err}, 128'd0);
    tick();
    tick();
    drive_idle(1'b0);
    Rst = 1'b0;
    tick();
    send_frame(16, 8, 1'b0, 12);
    chk("r1_locked", lk_post, 1'b0);
    send_frame(16, 8, 1'b0, 12);
    chk("r2_locked", lk_post, 1'b0);
    send_frame(16, 8, 1'b0, 12);
    chk("r3_locked", lk_post, 1'b0);
    send_frame(16, 8, 1'b0, 12);
    chk("r4_locked", lk_post, 1'b1);
    chk("r4_h_total", H_Total, 12'd24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule
